// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults, lane-slice width and FSM state encoding for fetch_scheduler.
package fetch_pkg;
  localparam int LANES_DEF  = 12;
  localparam int DATA_W_DEF = 8;
  localparam int IDX_W_DEF  = 4;
  localparam int SLICE_W    = DATA_W_DEF;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, OUT} state_t;
endpackage

// File: rtl/fetch_scheduler_rr_pick.sv
// rr_pick: combinational round-robin search from ptr upward, wrapping at LANES-1.
module rr_pick #(
  parameter int LANES = 12,
  parameter int IDX_W = 4
) (
  input  logic [LANES-1:0] elig,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  always_comb begin
    found = 1'b0;
    idx   = '0;
    // descending scan so the lane closest to ptr is written last and wins
    for (int i = LANES - 1; i >= 0; i--) begin
      int c;
      c = (int'(ptr) + i >= LANES) ? int'(ptr) + i - LANES : int'(ptr) + i;
      if (elig[c]) begin
        found = 1'b1;
        idx   = IDX_W'(c);
      end
    end
  end
endmodule

// File: rtl/fetch_scheduler.sv
// fetch_scheduler: round-robin one-word-at-a-time forwarder from a multi-lane fetcher.
// Define FETCH_SCHED_CNT_EN to add the 16-bit word_cnt handshake counter output.
module fetch_scheduler
  import fetch_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int DATA_W = SLICE_W,
  parameter int IDX_W  = IDX_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LANES-1:0]    lane_empty,
  input  logic [LANES*DATA_W-1:0] lane_data,
  input  logic [LANES-1:0]    lane_mask,
  output logic [LANES-1:0]    lane_read,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [IDX_W-1:0]    out_lane
`ifdef FETCH_SCHED_CNT_EN
  ,
  output logic [15:0]         word_cnt
`endif
);
  state_t state_q, state_d;
  logic [IDX_W-1:0]  g_q, g_d, p_q, p_d, pick_idx;
  logic [LANES-1:0]  lane_read_q, lane_read_d, elig;
  logic              out_valid_q, out_valid_d, found, grant;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]  out_lane_q, out_lane_d;

  assign elig = ~lane_empty & lane_mask;

  rr_pick #(.LANES(LANES), .IDX_W(IDX_W)) u_pick (
    .elig (elig),
    .ptr  (p_q),
    .found(found),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;

  always_comb begin
    state_d = (state_q == IDLE)    ? (found ? ISSUE : IDLE) :
              (state_q == ISSUE)   ? CAPTURE :
              (state_q == CAPTURE) ? OUT :
              (out_ready ? IDLE : OUT);
  end

  // eligibility only matters in IDLE; later states run to completion regardless
  always_comb begin
    grant       = (state_q == IDLE) && found;
    g_d         = grant ? pick_idx : g_q;
    p_d         = grant ? ((int'(pick_idx) == LANES - 1) ? '0 : pick_idx + 1'b1) : p_q;
    lane_read_d = grant ? (LANES'(1) << pick_idx) : '0;
    out_valid_d = (state_q == CAPTURE) ? 1'b1 : (state_q == OUT && out_ready) ? 1'b0 : out_valid_q;
    out_data_d  = (state_q == CAPTURE) ? lane_data[int'(g_q)*DATA_W +: DATA_W] : out_data_q;
    out_lane_d  = (state_q == CAPTURE) ? g_q : out_lane_q;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      g_q         <= '0;
      p_q         <= '0;
      lane_read_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= '0;
    end else begin
      g_q         <= g_d;
      p_q         <= p_d;
      lane_read_q <= lane_read_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lane_q  <= out_lane_d;
    end

  assign lane_read = lane_read_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_lane  = out_lane_q;

`ifdef FETCH_SCHED_CNT_EN
  logic [15:0] word_cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst)                          word_cnt_q <= '0;
    else if (out_valid_q && out_ready) word_cnt_q <= word_cnt_q + 16'd1;
  assign word_cnt = word_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_scheduler.sv
// tb_fetch_scheduler: directed self-checking bench for fetch_scheduler.
module tb_fetch_scheduler;
  localparam int LANES = 12;
  localparam int DW    = 8;
  localparam int IW    = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [LANES-1:0]    lane_empty = '1;
  logic [LANES*DW-1:0] lane_data;
  logic [LANES-1:0]    lane_mask = '1;
  logic [LANES-1:0]    lane_read;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [DW-1:0]       out_data;
  logic [IW-1:0]       out_lane;
`ifdef FETCH_SCHED_CNT_EN
  logic [15:0]         word_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  fetch_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .lane_empty(lane_empty),
    .lane_data (lane_data),
    .lane_mask (lane_mask),
    .lane_read (lane_read),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lane  (out_lane)
`ifdef FETCH_SCHED_CNT_EN
    ,
    .word_cnt  (word_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_grant(output logic [IW-1:0] lane, output logic [DW-1:0] data);
    int k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    chk("grant_valid", 64'(out_valid), 64'd1);
    lane = out_lane;
    data = out_data;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
  endtask

  logic [IW-1:0] gl;
  logic [DW-1:0] gd;
  logic [IW-1:0] exp_order [4] = '{4'd0, 4'd5, 4'd11, 4'd0};

  initial begin
    for (int k = 0; k < LANES; k++) lane_data[k*DW +: DW] = 8'hA0 + 8'(k);
    tick(2);
    chk("rst_lane_read", 64'(lane_read), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data",  64'(out_data),  64'h0);
    chk("rst_out_lane",  64'(out_lane),  64'h0);

    // single lane 0, 3-cycle latency
    rst = 1'b1;
    lane_empty = ~12'h001;
    tick();
    chk("l0_issue_read", 64'(lane_read), 64'h001);
    chk("l0_issue_valid", 64'(out_valid), 64'h0);
    tick();
    chk("l0_capture_read", 64'(lane_read), 64'h000);
    chk("l0_capture_valid", 64'(out_valid), 64'h0);
    tick();
    lane_empty = '1;
    chk("l0_out_valid", 64'(out_valid), 64'h1);
    chk("l0_out_data",  64'(out_data),  64'hA0);
    chk("l0_out_lane",  64'(out_lane),  64'h0);
    tick();
    chk("l0_done_valid", 64'(out_valid), 64'h0);

    // round-robin 0,5,11 with wrap
    do_reset();
    lane_empty = ~12'b1000_0010_0001;
    for (int i = 0; i < 4; i++) begin
      wait_grant(gl, gd);
      chk($sformatf("rr_lane%0d", i), 64'(gl), 64'(exp_order[i]));
      chk($sformatf("rr_data%0d", i), 64'(gd), 64'(8'hA0 + 8'(exp_order[i])));
      tick();
    end

    // backpressure: next grant must be lane 5, held for 10 cycles
    out_ready = 1'b0;
    wait_grant(gl, gd);
    chk("bp_lane", 64'(gl), 64'd5);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("bp_hold%0d", i), {out_valid, out_data, out_lane, lane_read},
          {1'b1, 8'hA5, 4'd5, 12'h000});
    end
    out_ready = 1'b1;
    lane_empty = '1;
    tick();
    chk("bp_release_valid", 64'(out_valid), 64'h0);

    // nothing eligible when all masked
    lane_mask = '0;
    lane_empty = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("mask_idle%0d", i), {out_valid, lane_read}, {1'b0, 12'h000});
    end

    // reset mid-transaction, then pointer restarts at lane 0
    lane_mask = '1;
    lane_empty = ~12'h088;
    tick();
    chk("pre_rst_issue", 64'(lane_read), 64'h080);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_cap_valid", 64'(out_valid), 64'h0);
    chk("rst_cap_read", 64'(lane_read), 64'h0);
    tick(2);
    chk("rst_cap_no_strobe", 64'(lane_read), 64'h0);
    rst = 1'b1;
    tick();
    chk("post_rst_grant3", 64'(lane_read), 64'h008);
    tick(2);
    chk("post_rst_data", {out_valid, out_data, out_lane}, {1'b1, 8'hA3, 4'd3});
    lane_empty = '1;
    rst = 1'b0;
    #2;
    chk("async_rst_out", {out_valid, out_data, out_lane}, {1'b0, 8'h00, 4'd0});
    tick();
    rst = 1'b1;

`ifdef FETCH_SCHED_CNT_EN
    do_reset();
    chk("cnt_reset", 64'(word_cnt), 64'd0);
    lane_empty = ~12'h001;
    for (int i = 0; i < 5; i++) begin
      wait_grant(gl, gd);
      tick();
    end
    lane_empty = '1;
    tick(2);
    chk("cnt_five", 64'(word_cnt), 64'd5);
    force dut.word_cnt_q = 16'hFFFF;
    tick();
    release dut.word_cnt_q;
    lane_empty = ~12'h001;
    wait_grant(gl, gd);
    lane_empty = '1;
    tick(2);
    chk("cnt_wrap", 64'(word_cnt), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
